// File: rtl/dcache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_refill_ctrl
//
// Miss sequencer for the MEM-stage data cache. On a miss it writes back the
// dirty victim line, if there is one. It then refills the missing line one
// word at a time from main memory. Finally it writes the new tag. While it
// works, it holds the global pipeline stall high.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   MemReqM         MEM-stage access is a load or store
//   AddrM           byte address of the MEM-stage access
//   HitM            tag compare hit (valid & tag match)
//   DirtyM          indexed victim line is valid and dirty
//   VictimAddrM     byte address of the victim line
//   mem_ack         main memory moved one word this cycle
//   stall           freeze PC and all pipeline registers
//   mem_req         word transfer request to main memory
//   mem_we          1 = writeback word, 0 = refill read
//   mem_addr        word-aligned main-memory byte address
//   wb_rd_idx       victim word index driven onto memory write data
//   fill_we         write returned memory data into the cache line
//   fill_word_idx   word index for fill_we
//   tag_we          write new tag, set valid, clear dirty
//   busy            sequencer not idle
//   miss_count      saturating miss counter
// ---------------------------------------------------------------------------
module dcache_refill_ctrl #(
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          MemReqM,
  input  logic [31:0]                   AddrM,
  input  logic                          HitM,
  input  logic                          DirtyM,
  input  logic [31:0]                   VictimAddrM,
  input  logic                          mem_ack,
  output logic                          stall,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  output logic [$clog2(LINE_WORDS)-1:0] wb_rd_idx,
  output logic                          fill_we,
  output logic [$clog2(LINE_WORDS)-1:0] fill_word_idx,
  output logic                          tag_we,
  output logic                          busy,
  output logic [31:0]                   miss_count
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam int OFF_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_REFILL,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       miss_base_q, miss_base_d;
  logic [31:0]       victim_base_q, victim_base_d;
  logic [31:0]       miss_count_q, miss_count_d;
  logic              miss;

  // The perf counter sticks at all-ones instead of wrapping to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Line bases keep their low bits at zero. Appending the word index and a
  // zero byte offset is therefore the same as base + 4*cnt, without a carry chain.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [CNT_W-1:0] idx);
    return {base[31:OFF_W], idx, 2'b00};
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return {a[31:OFF_W], {OFF_W{1'b0}}};
  endfunction

  assign miss       = MemReqM & ~HitM;
  assign miss_count = miss_count_q;
  assign busy       = (state_q != S_IDLE);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    miss_base_d   = miss_base_q;
    victim_base_d = victim_base_q;
    miss_count_d  = miss_count_q;
    stall         = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = 32'd0;
    wb_rd_idx     = '0;
    fill_we       = 1'b0;
    fill_word_idx = '0;
    tag_we        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Stall goes high in the same cycle as the miss. The MEM-stage
        // access then stays frozen until the line is ready.
        stall = miss;
        if (miss) begin
          miss_base_d   = line_base(AddrM);
          victim_base_d = line_base(VictimAddrM);
          cnt_d         = '0;
          miss_count_d  = sat_inc(miss_count_q);
          state_d       = DirtyM ? S_WB : S_REFILL;
        end
      end
      S_WB: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = word_addr(victim_base_q, cnt_q);
        wb_rd_idx = cnt_q;
        if (mem_ack) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_REFILL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_REFILL: begin
        stall         = 1'b1;
        mem_req       = 1'b1;
        mem_addr      = word_addr(miss_base_q, cnt_q);
        fill_we       = mem_ack;
        fill_word_idx = cnt_q;
        if (mem_ack) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        stall   = 1'b1;
        tag_we  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      miss_base_q   <= '0;
      victim_base_q <= '0;
      miss_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      miss_base_q   <= miss_base_d;
      victim_base_q <= victim_base_d;
      miss_count_q  <= miss_count_d;
    end
  end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
module tb_dcache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReqM;
  logic [31:0] AddrM;
  logic        HitM;
  logic        DirtyM;
  logic [31:0] VictimAddrM;
  logic        mem_ack;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  wb_rd_idx;
  logic        fill_we;
  logic [1:0]  fill_word_idx;
  logic        tag_we;
  logic        busy;
  logic [31:0] miss_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Observations from one miss sequence
  logic [31:0] rd_addr [8];
  logic [1:0]  rd_idx  [8];
  logic [31:0] wr_addr [8];
  logic [1:0]  wr_idx  [8];
  int nrd, nwr, ntag, stall_cyc, fill_bad, unstable, first_rd_cyc, last_wr_cyc;
  logic timed_out;

  always #5 clk = ~clk;

  dcache_refill_ctrl #(.LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .MemReqM(MemReqM), .AddrM(AddrM), .HitM(HitM),
    .DirtyM(DirtyM), .VictimAddrM(VictimAddrM), .mem_ack(mem_ack),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .wb_rd_idx(wb_rd_idx), .fill_we(fill_we), .fill_word_idx(fill_word_idx),
    .tag_we(tag_we), .busy(busy), .miss_count(miss_count)
  );

  // Moves to 1 time unit after the next rising edge. Inputs are driven here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one miss through to the retried IDLE cycle and records what it sees.
  // Main memory acks in every p-th busy cycle. The cache line becomes valid
  // (HitM=1) after tag_we.
  task automatic run_miss(input logic [31:0] addr, input logic [31:0] victim,
                          input logic dirty, input int p);
    logic        prev_req, prev_ack, tag_seen;
    logic [31:0] prev_addr;
    nrd = 0; nwr = 0; ntag = 0; stall_cyc = 0; fill_bad = 0; unstable = 0;
    first_rd_cyc = -1; last_wr_cyc = -1; timed_out = 1'b1;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'd0;
    MemReqM = 1'b1; AddrM = addr; VictimAddrM = victim; HitM = 1'b0;
    DirtyM = dirty; mem_ack = 1'b0;
    for (int k = 0; k < 80; k++) begin
      #1;
      if (stall) stall_cyc++;
      if (mem_req && mem_ack) begin
        if (mem_we) begin
          if (nwr < 8) begin wr_addr[nwr] = mem_addr; wr_idx[nwr] = wb_rd_idx; end
          nwr++;
          last_wr_cyc = k;
        end else begin
          if (nrd < 8) begin rd_addr[nrd] = mem_addr; rd_idx[nrd] = fill_word_idx; end
          if (first_rd_cyc < 0) first_rd_cyc = k;
          nrd++;
        end
      end
      if (fill_we !== (mem_req && !mem_we && mem_ack)) fill_bad++;
      if (mem_req && prev_req && !prev_ack && mem_addr !== prev_addr) unstable++;
      prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr;
      tag_seen = tag_we;
      if (tag_we) ntag++;
      if (ntag > 0 && !busy && !tag_we) begin
        timed_out = 1'b0;
        break;
      end
      next_cycle();
      if (tag_seen) HitM = 1'b1;
      mem_ack = ((k % p) == (p - 1));
    end
    next_cycle();
    MemReqM = 1'b0; HitM = 1'b0; DirtyM = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; MemReqM = 1'b0; AddrM = 32'd0; HitM = 1'b0; DirtyM = 1'b0;
    VictimAddrM = 32'd0; mem_ack = 1'b0;
    next_cycle(); next_cycle();
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b exp 0", mem_req); else n_pass++;
    n_checks++; if (miss_count !== 32'd0) $display("FAIL reset_miss_count: got %0d exp 0", miss_count); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall_noreq: got %b exp 0", stall); else n_pass++;
    // stall follows the IDLE miss equation even while reset is held
    MemReqM = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL reset_stall_miss: got %b exp 1", stall); else n_pass++;
    n_checks++; if ({tag_we, fill_we, wb_rd_idx, fill_word_idx} !== 6'd0)
      $display("FAIL reset_idle_outs: got %b exp 000000", {tag_we, fill_we, wb_rd_idx, fill_word_idx}); else n_pass++;
    MemReqM = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_hit_stream();
    int bad;
    bad = 0;
    MemReqM = 1'b1; HitM = 1'b1; AddrM = 32'h0000_0040;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (stall !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) bad++;
      next_cycle();
    end
    MemReqM = 1'b0; HitM = 1'b0;
    #1;
    n_checks++; if (bad !== 0) $display("FAIL hit_stream_stall: got %0d bad cycles exp 0", bad); else n_pass++;
    n_checks++; if (miss_count !== 32'd0) $display("FAIL hit_stream_count: got %0d exp 0", miss_count); else n_pass++;
    next_cycle();
  endtask

  task automatic test_clean_miss();
    run_miss(32'h0000_1234, 32'h0000_9990, 1'b0, 1);
    n_checks++; if (timed_out) $display("FAIL clean_timeout: got timeout exp completion"); else n_pass++;
    n_checks++; if (nrd !== 4) $display("FAIL clean_nreads: got %0d exp 4", nrd); else n_pass++;
    n_checks++; if (nwr !== 0) $display("FAIL clean_nwrites: got %0d exp 0", nwr); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd_addr[i] !== 32'h0000_1230 + 32'(4 * i) || rd_idx[i] !== 2'(i))
        $display("FAIL clean_read%0d: got addr %h idx %0d exp addr %h idx %0d",
                 i, rd_addr[i], rd_idx[i], 32'h0000_1230 + 32'(4 * i), i);
      else n_pass++;
    end
    n_checks++; if (ntag !== 1) $display("FAIL clean_tag_we: got %0d pulses exp 1", ntag); else n_pass++;
    n_checks++; if (stall_cyc !== 6) $display("FAIL clean_stall_len: got %0d exp 6", stall_cyc); else n_pass++;
    n_checks++; if (fill_bad !== 0) $display("FAIL clean_fill_we: got %0d bad cycles exp 0", fill_bad); else n_pass++;
    n_checks++; if (miss_count !== 32'd1) $display("FAIL clean_miss_count: got %0d exp 1", miss_count); else n_pass++;
  endtask

  task automatic test_dirty_miss();
    run_miss(32'h0000_4568, 32'h0000_8230, 1'b1, 1);
    n_checks++; if (timed_out) $display("FAIL dirty_timeout: got timeout exp completion"); else n_pass++;
    n_checks++; if (nwr !== 4 || nrd !== 4) $display("FAIL dirty_counts: got wr %0d rd %0d exp 4 4", nwr, nrd); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (wr_addr[i] !== 32'h0000_8230 + 32'(4 * i) || wr_idx[i] !== 2'(i))
        $display("FAIL dirty_write%0d: got addr %h idx %0d exp addr %h idx %0d",
                 i, wr_addr[i], wr_idx[i], 32'h0000_8230 + 32'(4 * i), i);
      else n_pass++;
      n_checks++;
      if (rd_addr[i] !== 32'h0000_4560 + 32'(4 * i))
        $display("FAIL dirty_read%0d: got %h exp %h", i, rd_addr[i], 32'h0000_4560 + 32'(4 * i));
      else n_pass++;
    end
    n_checks++; if (first_rd_cyc <= last_wr_cyc) $display("FAIL dirty_order: got first read cycle %0d exp after %0d", first_rd_cyc, last_wr_cyc); else n_pass++;
    n_checks++; if (stall_cyc !== 10) $display("FAIL dirty_stall_len: got %0d exp 10", stall_cyc); else n_pass++;
    n_checks++; if (miss_count !== 32'd2) $display("FAIL dirty_miss_count: got %0d exp 2", miss_count); else n_pass++;
  endtask

  task automatic test_slow_memory();
    run_miss(32'h0000_2004, 32'h0000_0000, 1'b0, 3);
    n_checks++; if (timed_out) $display("FAIL slow_timeout: got timeout exp completion"); else n_pass++;
    n_checks++; if (stall_cyc !== 14) $display("FAIL slow_stall_len: got %0d exp 14", stall_cyc); else n_pass++;
    n_checks++; if (unstable !== 0) $display("FAIL slow_addr_stable: got %0d changes exp 0", unstable); else n_pass++;
    n_checks++; if (fill_bad !== 0) $display("FAIL slow_fill_we: got %0d bad cycles exp 0", fill_bad); else n_pass++;
    n_checks++; if (nrd !== 4 || rd_addr[3] !== 32'h0000_200C)
      $display("FAIL slow_reads: got %0d reads last %h exp 4 last 0000200c", nrd, rd_addr[3]); else n_pass++;
    n_checks++; if (miss_count !== 32'd3) $display("FAIL slow_miss_count: got %0d exp 3", miss_count); else n_pass++;
  endtask

  task automatic test_spurious_ack();
    int bad;
    bad = 0;
    MemReqM = 1'b0; mem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (fill_we !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0 || tag_we !== 1'b0) bad++;
      next_cycle();
    end
    mem_ack = 1'b0;
    n_checks++; if (bad !== 0) $display("FAIL spurious_ack_idle: got %0d bad cycles exp 0", bad); else n_pass++;
    // A spurious ack must not have advanced the word counter
    run_miss(32'h0000_0A10, 32'h0000_0000, 1'b0, 1);
    n_checks++; if (rd_addr[0] !== 32'h0000_0A10 || rd_idx[0] !== 2'd0)
      $display("FAIL spurious_first_word: got %h idx %0d exp 00000a10 idx 0", rd_addr[0], rd_idx[0]); else n_pass++;
  endtask

  task automatic test_reset_mid_refill();
    int tag_pulses;
    tag_pulses = 0;
    MemReqM = 1'b1; AddrM = 32'h0000_3000; HitM = 1'b0; DirtyM = 1'b0; mem_ack = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL midrst_detect_stall: got %b exp 1", stall); else n_pass++;
    next_cycle(); mem_ack = 1'b1;
    next_cycle();
    next_cycle(); mem_ack = 1'b0; rst = 1'b1;
    #1;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_3008)
      $display("FAIL midrst_progress: got req %b addr %h exp req 1 addr 00003008", mem_req, mem_addr); else n_pass++;
    next_cycle();
    rst = 1'b0; MemReqM = 1'b0;
    #1;
    n_checks++; if ({busy, mem_req, fill_we, tag_we, stall} !== 5'd0)
      $display("FAIL midrst_idle: got busy/req/fill/tag/stall %b exp 00000", {busy, mem_req, fill_we, tag_we, stall}); else n_pass++;
    n_checks++; if (miss_count !== 32'd0) $display("FAIL midrst_miss_count: got %0d exp 0", miss_count); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (tag_we) tag_pulses++;
      next_cycle();
    end
    n_checks++; if (tag_pulses !== 0) $display("FAIL midrst_no_tag_we: got %0d pulses exp 0", tag_pulses); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_hit_stream();
    test_clean_miss();
    test_dirty_miss();
    test_slow_memory();
    test_spurious_ack();
    test_reset_mid_refill();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
